// File: rtl/base_splat_fifo.sv
// base_splat_fifo: multi-lane compacting FIFO.
// A beat of up to `ways` lanes is accepted per cycle. Only the lanes whose
// mask bit is set are stored, and they are packed into consecutive entries
// with lane 0 stored first. Entries come out one at a time in arrival order.
// Optional macro BASE_SPLAT_FIFO_PROTO_CHK_EN adds a sticky error flag that
// is set if a stalled input beat changes or is withdrawn before acceptance.
module base_splat_fifo #(
  parameter int ways  = 4,
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_v,
  output logic                       i_r,
  input  logic [0:ways-1]            i_m,
  input  logic [0:ways*width-1]      i_d,
  output logic [0:ways*$clog2(ways)-1] o_a,
  output logic [0:$clog2(ways+1)-1]  o_nr,
  output logic                       o_v,
  input  logic                       o_r,
  output logic [0:width-1]           o_d,
  output logic [0:$clog2(depth)]     o_cnt,
  output logic                       o_err
);

  localparam int w_width = $clog2(ways);
  localparam int n_width = $clog2(ways+1);
  localparam int a_width = $clog2(depth);
  localparam int c_width = a_width + 1;

  logic [a_width-1:0] wr_ptr;
  logic [a_width-1:0] rd_ptr;
  logic [width-1:0]   mem [depth];
  logic [c_width-1:0] free_slots;
  logic               accept;
  logic               pop;
  logic [n_width-1:0] run_cnt;

  // Prefix popcount of the mask gives each lane its packed slot offset;
  // the final running total is the number of lanes in the beat.
  always_comb begin
    run_cnt = '0;
    o_a     = '0;
    for (int k = 0; k < ways; k++) begin
      o_a[k*w_width +: w_width] = w_width'(run_cnt);
      run_cnt = run_cnt + n_width'(i_m[k]);
    end
    o_nr = run_cnt;
  end

  // Ready only looks at the registered occupancy so it never depends on
  // i_v or o_r; a same-cycle pop does not grant extra room.
  assign free_slots = c_width'(depth) - o_cnt;
  assign i_r        = free_slots >= c_width'(o_nr);
  assign accept     = i_v && i_r;
  assign pop        = o_v && o_r;

  // Output side is driven purely from registered state.
  assign o_v = (o_cnt != '0);
  assign o_d = mem[rd_ptr];

  // Pointers and occupancy; the separate count keeps full and empty distinct.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_cnt  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + a_width'(o_nr);
      if (pop)    rd_ptr <= rd_ptr + a_width'(1);
      o_cnt <= o_cnt + (accept ? c_width'(o_nr) : '0) - (pop ? c_width'(1) : '0);
    end
  end

  // Storage is left unreset; each valid lane lands at wr_ptr plus its offset,
  // with the address wrapping naturally at the pointer width.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < ways; k++) begin
        if (i_m[k]) begin
          mem[wr_ptr + a_width'(o_a[k*w_width +: w_width])] <= i_d[k*width +: width];
        end
      end
    end
  end

`ifdef BASE_SPLAT_FIFO_PROTO_CHK_EN
  logic                   pend_q;
  logic [0:ways-1]        m_q;
  logic [0:ways*width-1]  d_q;
  logic                   err_q;

  // Remember a stalled beat and flag it if it is dropped or altered next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      m_q    <= '0;
      d_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= i_v && !i_r;
      m_q    <= i_m;
      d_q    <= i_d;
      if (pend_q && (!i_v || (i_m != m_q) || (i_d != d_q))) err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_base_splat_fifo.sv
// Directed bench for base_splat_fifo (ways=4, width=8, depth=16).
module tb_base_splat_fifo;

  logic        clk;
  logic        reset_n;
  logic        i_v;
  logic        i_r;
  logic [0:3]  i_m;
  logic [0:31] i_d;
  logic [0:7]  o_a;
  logic [0:2]  o_nr;
  logic        o_v;
  logic        o_r;
  logic [0:7]  o_d;
  logic [0:4]  o_cnt;
  logic        o_err;

  int checks   = 0;
  int failures = 0;

  base_splat_fifo #(.ways(4), .width(8), .depth(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_v(i_v), .i_r(i_r), .i_m(i_m), .i_d(i_d),
    .o_a(o_a), .o_nr(o_nr),
    .o_v(o_v), .o_r(o_r), .o_d(o_d),
    .o_cnt(o_cnt), .o_err(o_err)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] m, input logic [31:0] d);
    i_v = v;
    i_m = m;
    i_d = d;
    #1;
  endtask

  task automatic pushBeat(input logic [3:0] m, input logic [31:0] d);
    applyStimulus(1'b1, m, d);
    tick();
    i_v = 1'b0;
    i_m = 4'b0000;
    #1;
  endtask

  task automatic popCheck(input string tag, input logic [7:0] expected);
    checkOutput(tag, 64'(o_d), 64'(expected));
    o_r = 1'b1;
    tick();
    o_r = 1'b0;
  endtask

  task automatic drain(input int n);
    o_r = 1'b1;
    repeat (n) tick();
    o_r = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    i_v = 1'b0;
    i_m = 4'b1111;
    i_d = '0;
    o_r = 1'b0;
    #2;
    checkOutput("reset_cnt", 64'(o_cnt), 64'(0));
    checkOutput("reset_ov", 64'(o_v), 64'(0));
    checkOutput("reset_err", 64'(o_err), 64'(0));
    checkOutput("reset_ir", 64'(i_r), 64'(1));
    tick();
    reset_n = 1'b1;
    i_m = 4'b0000;
    #1;

    // Basic compaction: lanes 0,2,3 valid.
    applyStimulus(1'b1, 4'b1011, {8'hAA, 8'hBB, 8'hCC, 8'hDD});
    checkOutput("oa_1011", 64'(o_a), 64'(8'h16));
    checkOutput("nr_1011", 64'(o_nr), 64'(3));
    checkOutput("ir_empty", 64'(i_r), 64'(1));
    tick();
    i_v = 1'b0;
    i_m = 4'b0110;
    #1;
    checkOutput("oa_0110", 64'(o_a), 64'(8'h06));
    i_m = 4'b1111;
    #1;
    checkOutput("oa_1111", 64'(o_a), 64'(8'h1B));
    checkOutput("nr_1111", 64'(o_nr), 64'(4));
    i_m = 4'b0000;
    #1;
    checkOutput("cnt_after_1011", 64'(o_cnt), 64'(3));
    checkOutput("ov_after_1011", 64'(o_v), 64'(1));
    popCheck("pop_A", 8'hAA);
    popCheck("pop_C", 8'hCC);
    popCheck("pop_D", 8'hDD);
    checkOutput("empty_cnt", 64'(o_cnt), 64'(0));
    checkOutput("empty_ov", 64'(o_v), 64'(0));

    // Near-full back-pressure: 14 stored, 3-lane beat must stall.
    pushBeat(4'b1111, {8'h20, 8'h21, 8'h22, 8'h23});
    pushBeat(4'b1111, {8'h24, 8'h25, 8'h26, 8'h27});
    pushBeat(4'b1111, {8'h28, 8'h29, 8'h2A, 8'h2B});
    pushBeat(4'b1100, {8'h2C, 8'h2D, 8'hFF, 8'hFF});
    checkOutput("cnt_14", 64'(o_cnt), 64'(14));
    applyStimulus(1'b1, 4'b1110, {8'hE0, 8'hE1, 8'hE2, 8'hE3});
    checkOutput("ir_stall_14", 64'(i_r), 64'(0));
    o_r = 1'b1;
    tick();
    o_r = 1'b0;
    #1;
    checkOutput("cnt_13", 64'(o_cnt), 64'(13));
    checkOutput("ir_room_13", 64'(i_r), 64'(1));
    tick();
    i_v = 1'b0;
    i_m = 4'b0000;
    #1;
    checkOutput("cnt_full", 64'(o_cnt), 64'(16));
    checkOutput("ir_full_empty_mask", 64'(i_r), 64'(1));
    i_m = 4'b1000;
    #1;
    checkOutput("ir_full_one_lane", 64'(i_r), 64'(0));
    i_m = 4'b0000;
    #1;
    for (int i = 0; i < 13; i++) popCheck("drain_full", 8'(8'h21 + i));
    popCheck("drain_E0", 8'hE0);
    popCheck("drain_E1", 8'hE1);
    popCheck("drain_E2", 8'hE2);
    checkOutput("drained_cnt", 64'(o_cnt), 64'(0));

    // Move wr_ptr from 4 to 14, then straddle the wrap point.
    pushBeat(4'b1111, {8'h30, 8'h31, 8'h32, 8'h33});
    pushBeat(4'b1111, {8'h34, 8'h35, 8'h36, 8'h37});
    pushBeat(4'b1100, {8'h38, 8'h39, 8'hFF, 8'hFF});
    drain(10);
    checkOutput("pre_wrap_cnt", 64'(o_cnt), 64'(0));
    pushBeat(4'b1111, {8'hA0, 8'hA1, 8'hA2, 8'hA3});
    checkOutput("wrap_cnt", 64'(o_cnt), 64'(4));
    popCheck("wrap_W", 8'hA0);
    popCheck("wrap_X", 8'hA1);
    popCheck("wrap_Y", 8'hA2);
    popCheck("wrap_Z", 8'hA3);
    pushBeat(4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hB0});
    popCheck("after_wrap", 8'hB0);

    // Simultaneous push and pop, then an empty-mask handshake.
    pushBeat(4'b1111, {8'h50, 8'h51, 8'h52, 8'h53});
    pushBeat(4'b1000, {8'h54, 8'hFF, 8'hFF, 8'hFF});
    checkOutput("cnt_5", 64'(o_cnt), 64'(5));
    o_r = 1'b1;
    pushBeat(4'b0110, {8'hFF, 8'h55, 8'h56, 8'hFF});
    o_r = 1'b0;
    checkOutput("cnt_push_pop", 64'(o_cnt), 64'(6));
    applyStimulus(1'b1, 4'b0000, {8'h11, 8'h22, 8'h33, 8'h44});
    checkOutput("ir_zero_mask", 64'(i_r), 64'(1));
    tick();
    i_v = 1'b0;
    #1;
    checkOutput("cnt_zero_mask", 64'(o_cnt), 64'(6));
    popCheck("pp_51", 8'h51);
    popCheck("pp_52", 8'h52);
    popCheck("pp_53", 8'h53);
    popCheck("pp_54", 8'h54);
    popCheck("pp_55", 8'h55);
    popCheck("pp_56", 8'h56);

    // Asynchronous reset in the middle of traffic.
    pushBeat(4'b1111, {8'h60, 8'h61, 8'h62, 8'h63});
    pushBeat(4'b1111, {8'h64, 8'h65, 8'h66, 8'h67});
    pushBeat(4'b1000, {8'h68, 8'hFF, 8'hFF, 8'hFF});
    checkOutput("cnt_9", 64'(o_cnt), 64'(9));
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_cnt", 64'(o_cnt), 64'(0));
    checkOutput("async_rst_ov", 64'(o_v), 64'(0));
    #1;
    reset_n = 1'b1;
    #1;
    pushBeat(4'b0011, {8'hFF, 8'hFF, 8'h70, 8'h71});
    checkOutput("post_rst_cnt", 64'(o_cnt), 64'(2));
    popCheck("post_rst_first", 8'h70);
    popCheck("post_rst_second", 8'h71);

    // Stalled beat whose mask changes before acceptance.
    pushBeat(4'b1111, {8'h80, 8'h81, 8'h82, 8'h83});
    pushBeat(4'b1111, {8'h84, 8'h85, 8'h86, 8'h87});
    pushBeat(4'b1111, {8'h88, 8'h89, 8'h8A, 8'h8B});
    pushBeat(4'b1111, {8'h8C, 8'h8D, 8'h8E, 8'h8F});
    applyStimulus(1'b1, 4'b1000, {8'h90, 8'hFF, 8'hFF, 8'hFF});
    checkOutput("ir_stall_full", 64'(i_r), 64'(0));
    tick();
    i_m = 4'b0100;
    #1;
    tick();
`ifdef BASE_SPLAT_FIFO_PROTO_CHK_EN
    checkOutput("err_set", 64'(o_err), 64'(1));
    i_v = 1'b0;
    i_m = 4'b0000;
    tick();
    checkOutput("err_sticky", 64'(o_err), 64'(1));
`else
    checkOutput("err_tied_low", 64'(o_err), 64'(0));
    i_v = 1'b0;
    i_m = 4'b0000;
    tick();
`endif
    reset_n = 1'b0;
    #1;
    checkOutput("err_after_rst", 64'(o_err), 64'(0));
    checkOutput("cnt_after_rst", 64'(o_cnt), 64'(0));
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
